mac_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single 32-bit MAC TX AXI-Stream port between N_PORTS requester streams. A grant is locked from a packet's first beat until its tlast beat, so packets are never interleaved. The block sits between the protocol engines and the MAC TX interface, and drives the MAC (or the MAC emulator in simulation) through one registered output stage.

---
 rtl/mac_stream_pkg.sv | 16 +
 rtl/mac_tx_arbiter_rr_pick.sv | 32 +++
 rtl/mac_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_stream_pkg.sv
// Shared stream widths, keep constants and arbiter state encoding.
package mac_stream_pkg;

   localparam int BEAT_W = 32;
   localparam int KEEP_W = 4;

   localparam logic [KEEP_W-1:0] KEEP_FULL = 4'b1111;
   localparam logic [KEEP_W-1:0] KEEP_NONE = 4'b0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PKT   = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mac_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first request after i_ptr, wrapping.
module rr_pick
   import mac_stream_pkg::*;
#(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
)(
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_hit,
   output logic [IDX_W-1:0] o_idx
);

   always_comb begin
      int               w_sum;
      logic [IDX_W-1:0] w_j;
      o_hit = 1'b0;
      o_idx = '0;
      w_sum = 0;
      w_j   = '0;
      // i runs 1..N so the pointer's own port is searched last
      for (int i = 1; i <= N; i++) begin
         w_sum = (int'(i_ptr) + i) % N;
         w_j   = IDX_W'(w_sum);
         if (!o_hit && i_req[w_j]) begin
            o_hit = 1'b1;
            o_idx = w_j;
         end
      end
   end

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-locked round-robin arbiter onto the MAC TX stream.
// MAC_TX_ARB_TIMEOUT_EN adds a mid-packet stall abort with a DRAIN state.
module mac_tx_arbiter
   import mac_stream_pkg::*;
#(
   parameter int N_PORTS        = 4,
   parameter int IDX_W          = $clog2(N_PORTS),
   parameter int TIMEOUT_CYCLES = 1024
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_PORTS*BEAT_W-1:0] s_tdata,
   input  logic [N_PORTS*KEEP_W-1:0] s_tkeep,
   input  logic [N_PORTS-1:0]        s_tvalid,
   input  logic [N_PORTS-1:0]        s_tlast,
   output logic [N_PORTS-1:0]        s_tready,
   output logic [BEAT_W-1:0]         mac_tx_tdata,
   output logic [KEEP_W-1:0]         mac_tx_tkeep,
   output logic                      mac_tx_tvalid,
   output logic                      mac_tx_tlast,
   input  logic                      mac_tx_tready,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy,
   output logic                      tx_abort
);

   arb_state_t        r_state;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  r_grant;
   logic [BEAT_W-1:0] r_tdata;
   logic [KEEP_W-1:0] r_tkeep;
   logic              r_tvalid;
   logic              r_tlast;

   logic              w_hit;
   logic [IDX_W-1:0]  w_win;
   logic              w_sel_valid;
   logic              w_sel_last;
   logic [BEAT_W-1:0] w_sel_data;
   logic [KEEP_W-1:0] w_sel_keep;
   logic              w_out_free;
   logic              w_acc;
   logic [N_PORTS-1:0] w_ready;
   logic              w_unused_cfg;

   rr_pick #(
      .N     (N_PORTS),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_req (s_tvalid),
      .i_ptr (r_ptr),
      .o_hit (w_hit),
      .o_idx (w_win)
   );

   assign w_sel_valid = s_tvalid[r_grant];
   assign w_sel_last  = s_tlast[r_grant];
   assign w_sel_data  = s_tdata[int'(r_grant)*BEAT_W +: BEAT_W];
   assign w_sel_keep  = s_tkeep[int'(r_grant)*KEEP_W +: KEEP_W];

   assign w_out_free = !r_tvalid || mac_tx_tready;
   assign w_acc      = (r_state == PKT) && w_sel_valid && w_out_free;

   always_comb begin
      w_ready = '0;
      if (r_state == PKT)
         w_ready[r_grant] = w_out_free;
`ifdef MAC_TX_ARB_TIMEOUT_EN
      else if (r_state == DRAIN)
         w_ready[r_grant] = 1'b1;
`endif
   end

`ifdef MAC_TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_stall;
   logic             r_abort;
   logic             w_tmo;

   assign w_tmo = (r_state == PKT) && (r_stall == CNT_MAX) &&
                  w_out_free && !w_acc;
   assign tx_abort = r_abort;
`else
   assign tx_abort = 1'b0;
`endif

   assign w_unused_cfg = (^KEEP_FULL) ^ (TIMEOUT_CYCLES == 0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_ptr    <= IDX_W'(N_PORTS - 1);
         r_grant  <= '0;
         r_tdata  <= '0;
         r_tkeep  <= KEEP_NONE;
         r_tvalid <= 1'b0;
         r_tlast  <= 1'b0;
`ifdef MAC_TX_ARB_TIMEOUT_EN
         r_stall  <= '0;
         r_abort  <= 1'b0;
`endif
      end else begin
`ifdef MAC_TX_ARB_TIMEOUT_EN
         r_abort <= 1'b0;
`endif
         if (w_acc) begin
            r_tdata  <= w_sel_data;
            r_tkeep  <= w_sel_keep;
            r_tlast  <= w_sel_last;
            r_tvalid <= 1'b1;
         end
`ifdef MAC_TX_ARB_TIMEOUT_EN
         // terminate the truncated packet with an empty last beat
         else if (w_tmo) begin
            r_tdata  <= '0;
            r_tkeep  <= KEEP_NONE;
            r_tlast  <= 1'b1;
            r_tvalid <= 1'b1;
         end
`endif
         else if (mac_tx_tready)
            r_tvalid <= 1'b0;

         case (r_state)
            IDLE: begin
               if (w_hit) begin
                  r_grant <= w_win;
                  r_ptr   <= w_win;
                  r_state <= PKT;
               end
            end
            PKT: begin
               if (w_acc && w_sel_last)
                  r_state <= IDLE;
`ifdef MAC_TX_ARB_TIMEOUT_EN
               if (w_acc)
                  r_stall <= '0;
               else if (w_tmo) begin
                  r_stall <= '0;
                  r_abort <= 1'b1;
                  r_state <= DRAIN;
               end else if (!w_sel_valid && r_stall != CNT_MAX)
                  r_stall <= r_stall + 1'b1;
`endif
            end
`ifdef MAC_TX_ARB_TIMEOUT_EN
            DRAIN: begin
               if (w_sel_valid && w_sel_last)
                  r_state <= IDLE;
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s_tready      = w_ready;
   assign mac_tx_tdata  = r_tdata;
   assign mac_tx_tkeep  = r_tkeep;
   assign mac_tx_tvalid = r_tvalid;
   assign mac_tx_tlast  = r_tlast;
   assign grant_id      = r_grant;
   assign busy          = (r_state != IDLE);

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed table-driven bench for mac_tx_arbiter with per-port beat queues.
`timescale 1ns/1ps
module tb_mac_tx_arbiter;

   localparam int N   = 4;
   localparam int TMO = 16;
`ifdef MAC_TX_ARB_TIMEOUT_EN
   localparam int GAP4 = 12;
`else
   localparam int GAP4 = 20;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N*32-1:0] s_tdata;
   logic [N*4-1:0]  s_tkeep;
   logic [N-1:0]  s_tvalid;
   logic [N-1:0]  s_tlast;
   logic [N-1:0]  s_tready;
   logic [31:0]   mac_tx_tdata;
   logic [3:0]    mac_tx_tkeep;
   logic          mac_tx_tvalid;
   logic          mac_tx_tlast;
   logic          mac_tx_tready;
   logic [1:0]    grant_id;
   logic          busy;
   logic          tx_abort;

   mac_tx_arbiter #(
      .N_PORTS        (N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_tdata       (s_tdata),
      .s_tkeep       (s_tkeep),
      .s_tvalid      (s_tvalid),
      .s_tlast       (s_tlast),
      .s_tready      (s_tready),
      .mac_tx_tdata  (mac_tx_tdata),
      .mac_tx_tkeep  (mac_tx_tkeep),
      .mac_tx_tvalid (mac_tx_tvalid),
      .mac_tx_tlast  (mac_tx_tlast),
      .mac_tx_tready (mac_tx_tready),
      .grant_id      (grant_id),
      .busy          (busy),
      .tx_abort      (tx_abort)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          tst;
      int          port;
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      int          pre;
      int          ord;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      int          pre;
   } beat_t;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic [1:0]  gid;
   } out_t;

   vec_t  vecs[$];
   beat_t pq[N][$];
   out_t  exp_a[64];
   out_t  got_q[$];
   int    exp_n = 0;

   int n_checks = 0;
   int n_errors = 0;
   int ncyc = 0;
   int first_out = -1;
   int rdy_multi = 0;
   int rdy_full = 0;
   int stalls = 0;
   int abort_cnt = 0;
   bit tog = 1'b0;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h want %h", nm, got, want);
      end
   endtask

   task automatic drive();
      beat_t b;
      for (int k = 0; k < N; k++) begin
         s_tvalid[k] = 1'b0;
         s_tlast[k]  = 1'b0;
         s_tdata[k*32 +: 32] = '0;
         s_tkeep[k*4 +: 4]   = '0;
         if (pq[k].size() > 0) begin
            b = pq[k][0];
            if (b.pre > 0) begin
               b.pre--;
               pq[k][0] = b;
            end else begin
               s_tvalid[k] = 1'b1;
               s_tlast[k]  = b.last;
               s_tdata[k*32 +: 32] = b.data;
               s_tkeep[k*4 +: 4]   = b.keep;
            end
         end
      end
   endtask

   task automatic cycle();
      logic [N-1:0] acc;
      @(negedge clk);
      ncyc++;
      acc = s_tvalid & s_tready;
      if ($countones(s_tready) > 1) rdy_multi++;
      if (mac_tx_tvalid && !mac_tx_tready) begin
         stalls++;
         if (s_tready != '0) rdy_full++;
      end
      if (tx_abort) abort_cnt++;
      if (mac_tx_tvalid && first_out < 0) first_out = ncyc;
      if (mac_tx_tvalid && mac_tx_tready)
         got_q.push_back('{mac_tx_tdata, mac_tx_tkeep,
                           mac_tx_tlast, grant_id});
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++)
         if (acc[k] && pq[k].size() > 0) void'(pq[k].pop_front());
      if (tog) mac_tx_tready = ~mac_tx_tready;
      drive();
   endtask

   task automatic run_wait(input int n, input int budget);
      int c;
      c = 0;
      while (got_q.size() < n && c < budget) begin
         cycle();
         c++;
      end
      if (got_q.size() < n) begin
         n_checks++;
         n_errors++;
         $display("FAIL wait_out: got %0d beats want %0d", got_q.size(), n);
      end
   endtask

   task automatic load_test(input int t);
      foreach (vecs[i]) begin
         if (vecs[i].tst == t) begin
            pq[vecs[i].port].push_back('{vecs[i].data, vecs[i].keep,
                                         vecs[i].last, vecs[i].pre});
            if (vecs[i].ord >= 0) begin
               exp_a[vecs[i].ord] = '{vecs[i].data, vecs[i].keep,
                                      vecs[i].last, 2'(vecs[i].port)};
               if (vecs[i].ord + 1 > exp_n) exp_n = vecs[i].ord + 1;
            end
         end
      end
      drive();
   endtask

   task automatic compare(input string nm, input bit use_gid);
      chk({nm, "_count"}, 32'(got_q.size()), 32'(exp_n));
      for (int i = 0; i < exp_n && i < got_q.size(); i++) begin
         chk($sformatf("%s_data%0d", nm, i), got_q[i].data, exp_a[i].data);
         chk($sformatf("%s_keep%0d", nm, i), 32'(got_q[i].keep),
             32'(exp_a[i].keep));
         chk($sformatf("%s_last%0d", nm, i), 32'(got_q[i].last),
             32'(exp_a[i].last));
         if (use_gid)
            chk($sformatf("%s_gid%0d", nm, i), 32'(got_q[i].gid),
                32'(exp_a[i].gid));
      end
      got_q.delete();
      exp_n = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      int t_start;

      // test, port, data, keep, last, idle-before, output position
      vecs.push_back('{1, 0, 32'h01020304, 4'hF, 1'b0, 0, 0});
      vecs.push_back('{1, 0, 32'h05060708, 4'hF, 1'b0, 0, 1});
      vecs.push_back('{1, 0, 32'h090A0B0C, 4'hC, 1'b1, 0, 2});
      // pointer sits on port 0, so rotation starts at port 1
      vecs.push_back('{2, 0, 32'hB2000000, 4'hF, 1'b0, 0, 6});
      vecs.push_back('{2, 0, 32'hB2000001, 4'hE, 1'b1, 0, 7});
      vecs.push_back('{2, 0, 32'hB2000100, 4'hF, 1'b0, 0, 14});
      vecs.push_back('{2, 0, 32'hB2000101, 4'hE, 1'b1, 0, 15});
      vecs.push_back('{2, 1, 32'hB2010000, 4'hF, 1'b0, 0, 0});
      vecs.push_back('{2, 1, 32'hB2010001, 4'hE, 1'b1, 0, 1});
      vecs.push_back('{2, 1, 32'hB2010100, 4'hF, 1'b0, 0, 8});
      vecs.push_back('{2, 1, 32'hB2010101, 4'hE, 1'b1, 0, 9});
      vecs.push_back('{2, 2, 32'hB2020000, 4'hF, 1'b0, 0, 2});
      vecs.push_back('{2, 2, 32'hB2020001, 4'hE, 1'b1, 0, 3});
      vecs.push_back('{2, 2, 32'hB2020100, 4'hF, 1'b0, 0, 10});
      vecs.push_back('{2, 2, 32'hB2020101, 4'hE, 1'b1, 0, 11});
      vecs.push_back('{2, 3, 32'hB2030000, 4'hF, 1'b0, 0, 4});
      vecs.push_back('{2, 3, 32'hB2030001, 4'hE, 1'b1, 0, 5});
      vecs.push_back('{2, 3, 32'hB2030100, 4'hF, 1'b0, 0, 12});
      vecs.push_back('{2, 3, 32'hB2030101, 4'hE, 1'b1, 0, 13});
      for (int i = 0; i < 5; i++)
         vecs.push_back('{3, 2, 32'h30000000 + 32'(i), 4'hF,
                          (i == 4), 0, i});
      vecs.push_back('{4, 1, 32'h41000000, 4'hF, 1'b0, 0, 0});
      vecs.push_back('{4, 1, 32'h41000001, 4'h8, 1'b1, GAP4, 1});
      vecs.push_back('{4, 3, 32'h43000000, 4'hF, 1'b0, 2, 2});
      vecs.push_back('{4, 3, 32'h43000001, 4'hF, 1'b1, 0, 3});
      for (int i = 0; i < 4; i++)
         vecs.push_back('{5, 0, 32'h50000000 + 32'(i), 4'hF,
                          (i == 3), 0, -1});
      vecs.push_back('{55, 2, 32'h52AA0000, 4'hF, 1'b1, 0, 1});
      vecs.push_back('{55, 0, 32'h50AA0000, 4'h3, 1'b1, 0, 0});
      vecs.push_back('{6, 0, 32'h60000000, 4'hF, 1'b0, 0, 0});
      vecs.push_back('{6, 0, 32'h60000001, 4'hF, 1'b0, 0, 1});
      vecs.push_back('{6, 0, 32'h60000002, 4'hF, 1'b0, 40, -1});
      vecs.push_back('{6, 0, 32'h60000003, 4'hF, 1'b1, 0, -1});
      vecs.push_back('{6, 1, 32'h61000000, 4'hF, 1'b1, 0, 3});

      rst_n = 1'b0;
      mac_tx_tready = 1'b1;
      drive();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 32'(mac_tx_tvalid), 32'd0);
      chk("rst_tdata", mac_tx_tdata, 32'd0);
      chk("rst_tkeep", 32'(mac_tx_tkeep), 32'd0);
      chk("rst_tlast", 32'(mac_tx_tlast), 32'd0);
      chk("rst_tready", 32'(s_tready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_abort", 32'(tx_abort), 32'd0);
      rst_n = 1'b1;
      repeat (2) cycle();
      chk("idle_busy", 32'(busy), 32'd0);

      // test 1: single port, latency of two clock edges
      load_test(1);
      t_start = ncyc;
      first_out = -1;
      repeat (2) cycle();
      chk("t1_busy", 32'(busy), 32'd1);
      run_wait(3, 50);
      chk("t1_latency", 32'(first_out - t_start), 32'd3);
      repeat (4) cycle();
      chk("t1_idle_busy", 32'(busy), 32'd0);
      compare("t1", 1'b0);

      // test 2: all ports busy, strict rotation
      load_test(2);
      run_wait(16, 300);
      repeat (4) cycle();
      compare("t2", 1'b1);

      // test 3: MAC backpressure toggling each cycle
      tog = 1'b1;
      load_test(3);
      run_wait(5, 100);
      tog = 1'b0;
      mac_tx_tready = 1'b1;
      repeat (4) cycle();
      compare("t3", 1'b0);
      chk("t3_stall_seen", 32'(stalls > 0), 32'd1);
      chk("t3_ready_full", 32'(rdy_full), 32'd0);

      // test 4: mid-packet gap keeps the grant
      load_test(4);
      run_wait(4, 200);
      repeat (4) cycle();
      compare("t4", 1'b1);
      chk("onehot_ready", 32'(rdy_multi), 32'd0);

      // test 5: reset in mid-packet
      load_test(5);
      run_wait(1, 20);
      rst_n = 1'b0;
      #1;
      chk("t5_tvalid", 32'(mac_tx_tvalid), 32'd0);
      chk("t5_tready", 32'(s_tready), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      for (int k = 0; k < N; k++) pq[k].delete();
      got_q.delete();
      exp_n = 0;
      drive();
      repeat (2) cycle();
      rst_n = 1'b1;
      load_test(55);
      run_wait(2, 50);
      repeat (4) cycle();
      compare("t5", 1'b1);

`ifdef MAC_TX_ARB_TIMEOUT_EN
      // test 6: stall abort, drain, then port 1
      abort_cnt = 0;
      load_test(6);
      exp_a[2] = '{32'h0, 4'h0, 1'b1, 2'd0};
      exp_n = 4;
      run_wait(4, 300);
      repeat (4) cycle();
      compare("t6", 1'b1);
      chk("t6_abort_pulses", 32'(abort_cnt), 32'd1);
      chk("t6_drained", 32'(pq[0].size()), 32'd0);
`else
      chk("no_abort", 32'(abort_cnt), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
